// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS CPU front end.
package mips_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_SKID = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] WORD_BYTES       = 32'd4;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~(WORD_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Fetch-to-decode register with a one-entry skid buffer that catches a
// memory word returning while decode is stalled.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        stall,
  input  logic        load_new,
  input  logic        load_skid,
  input  logic        skid_to_id,
  input  logic [31:0] new_instr,
  input  logic [31:0] new_pc,
  output logic        slot_free,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  assign slot_free = !id_valid || !stall;

  // Decode-facing register: a stalled slot holds, a free one drains unless refilled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (load_new) begin
      id_valid    <= 1'b1;
      id_instr    <= new_instr;
      id_pc       <= new_pc;
      id_pc_plus4 <= new_pc + WORD_BYTES;
    end else if (skid_to_id && skid_valid) begin
      id_valid    <= 1'b1;
      id_instr    <= skid_instr;
      id_pc       <= skid_pc;
      id_pc_plus4 <= skid_pc + WORD_BYTES;
    end else if (!stall) begin
      id_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (load_skid) begin
      skid_valid <= 1'b1;
      skid_instr <= new_instr;
      skid_pc    <= new_pc;
    end else if (skid_to_id) begin
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding memory request FSM and
// redirect handling; the decode register lives in if_id_reg.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         kill;
  logic         slot_free;
  logic         load_new;
  logic         load_skid;
  logic         skid_to_id;

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  // A redirect suppresses every load so nothing fetched on the old path survives.
  always_comb begin
    load_new   = 1'b0;
    load_skid  = 1'b0;
    skid_to_id = 1'b0;
    if (!redirect) begin
      case (state)
        S_WAIT: begin
          if (imem_valid && !kill) begin
            load_new  = slot_free;
            load_skid = !slot_free;
          end
        end
        S_SKID:  skid_to_id = !stall;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= '0;
      kill   <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          req_pc <= pc;
          state  <= S_WAIT;
          if (redirect) begin
            pc   <= align_word(redirect_pc);
            kill <= 1'b1;
          end else begin
            pc <= pc + WORD_BYTES;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            pc <= align_word(redirect_pc);
            if (imem_valid) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_valid) begin
            kill  <= 1'b0;
            state <= (kill || slot_free) ? S_REQ : S_SKID;
          end
        end
        S_SKID: begin
          if (redirect) begin
            pc    <= align_word(redirect_pc);
            state <= S_REQ;
          end else if (!stall) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (redirect),
    .stall       (stall),
    .load_new    (load_new),
    .load_skid   (load_skid),
    .skid_to_id  (skid_to_id),
    .new_instr   (imem_rdata),
    .new_pc      (req_pc),
    .slot_free   (slot_free),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scripted scenarios plus a random run
// checked against an in-order instruction-stream model.
module tb_fetch_stage;

  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int n_cmp = 0;
  int n_err = 0;
  int consumed = 0;
  int mem_lat = 1;
  bit mem_rand = 1'b0;

  fetch_stage dut (
    .clk         (clk),
    .rstn        (rstn),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4)
  );

  always #5 clk = ~clk;

  // Memory model: samples the request at the edge, answers after the latency
  // with addr ^ KEY, and forgets everything while reset is low.
  logic        req_s, rst_s, busy_s;
  logic [31:0] addr_s;
  logic [31:0] mem_addr;
  bit          mem_pending = 1'b0;
  int          mem_cnt = 0;
  int          lat;

  always @(posedge clk) begin
    req_s  = imem_req;
    addr_s = imem_addr;
    rst_s  = rstn;
    busy_s = mem_pending || imem_valid;
    #1;
    imem_valid = 1'b0;
    if (!rst_s) begin
      mem_pending = 1'b0;
    end else begin
      if (mem_pending) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_pending = 1'b0;
          imem_valid  = 1'b1;
          imem_rdata  = mem_addr ^ KEY;
        end
      end
      if (req_s) begin
        n_cmp++;
        if (busy_s) begin
          n_err++;
          $display("[TB] FAIL overlap: request to %h while busy=%b, required busy=0", addr_s, busy_s);
        end
        lat = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
        mem_addr = addr_s;
        if (lat == 1) begin
          imem_valid = 1'b1;
          imem_rdata = addr_s ^ KEY;
        end else begin
          mem_pending = 1'b1;
          mem_cnt     = lat - 1;
        end
      end
    end
  end

  // Stream model: decode consumes in program order; redirect restarts at the target.
  logic [31:0] exp_pc = RESET_PC;

  always @(negedge clk) begin
    if (!rstn) begin
      exp_pc = RESET_PC;
    end else if (redirect) begin
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else if (id_valid && !stall) begin
      n_cmp++;
      if (id_pc !== exp_pc || id_instr !== (exp_pc ^ KEY) || id_pc_plus4 !== exp_pc + 32'd4) begin
        n_err++;
        $display("[TB] FAIL stream: got pc=%h instr=%h plus4=%h, required pc=%h instr=%h plus4=%h",
                 id_pc, id_instr, id_pc_plus4, exp_pc, exp_pc ^ KEY, exp_pc + 32'd4);
      end
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int latency);
    rstn = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    mem_rand = 1'b0;
    mem_lat = latency;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    next_cycle();
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_id_valid: got %b, required 0", id_valid); end
    n_cmp++; if (id_instr !== 32'h0) begin n_err++; $display("[TB] FAIL reset_id_instr: got %h, required 0", id_instr); end
    n_cmp++; if (id_pc !== 32'h0) begin n_err++; $display("[TB] FAIL reset_id_pc: got %h, required 0", id_pc); end
    n_cmp++; if (id_pc_plus4 !== 32'h0) begin n_err++; $display("[TB] FAIL reset_id_pc_plus4: got %h, required 0", id_pc_plus4); end
    next_cycle();
    rstn = 1'b1;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("[TB] FAIL reset_req: got %b, required 1", imem_req); end
    n_cmp++; if (imem_addr !== RESET_PC) begin n_err++; $display("[TB] FAIL reset_addr: got %h, required %h", imem_addr, RESET_PC); end
  endtask

  task automatic test_basic();
    logic        exp_req, exp_v;
    logic [31:0] exp_a;
    do_reset(1);
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) next_cycle();
      exp_req = (c % 2 == 0);
      exp_v   = (c >= 2) && (c % 2 == 0);
      n_cmp++; if (imem_req !== exp_req) begin n_err++; $display("[TB] FAIL basic_req c%0d: got %b, required %b", c, imem_req, exp_req); end
      if (exp_req) begin
        exp_a = RESET_PC + 32'(2 * c);
        n_cmp++; if (imem_addr !== exp_a) begin n_err++; $display("[TB] FAIL basic_addr c%0d: got %h, required %h", c, imem_addr, exp_a); end
      end
      n_cmp++; if (id_valid !== exp_v) begin n_err++; $display("[TB] FAIL basic_valid c%0d: got %b, required %b", c, id_valid, exp_v); end
      if (exp_v) begin
        exp_a = RESET_PC + 32'(2 * (c - 2));
        n_cmp++; if (id_pc !== exp_a || id_instr !== (exp_a ^ KEY)) begin n_err++; $display("[TB] FAIL basic_id c%0d: got %h/%h, required %h/%h", c, id_pc, id_instr, exp_a, exp_a ^ KEY); end
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) next_cycle();
      if (c >= 3 && c <= 7) begin
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("[TB] FAIL stall_no_req c%0d: got %b, required 0", c, imem_req); end
      end
      if (c >= 2 && c <= 7) begin
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== RESET_PC) begin n_err++; $display("[TB] FAIL stall_hold c%0d: got v=%b pc=%h, required v=1 pc=%h", c, id_valid, id_pc, RESET_PC); end
      end
      if (c == 8) begin
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== RESET_PC + 32'd4) begin n_err++; $display("[TB] FAIL stall_skid_out: got v=%b pc=%h, required v=1 pc=%h", id_valid, id_pc, RESET_PC + 32'd4); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC + 32'd8) begin n_err++; $display("[TB] FAIL stall_resume: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, RESET_PC + 32'd8); end
      end
      stall = (c >= 2 && c <= 6);
    end
    stall = 1'b0;
  endtask

  task automatic test_redirect_wait();
    do_reset(3);
    next_cycle();
    redirect = 1'b1;
    redirect_pc = 32'h0000_4001;
    for (int c = 2; c <= 8; c++) begin
      next_cycle();
      redirect = 1'b0;
      if (c < 8) begin
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rdw_valid c%0d: got %b, required 0", c, id_valid); end
      end
      if (c == 4) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_4000) begin n_err++; $display("[TB] FAIL rdw_req: got req=%b addr=%h, required req=1 addr=00004000", imem_req, imem_addr); end
      end else if (c < 8) begin
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("[TB] FAIL rdw_no_req c%0d: got %b, required 0", c, imem_req); end
      end
      if (c == 8) begin
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0000_4000 || id_instr !== (32'h0000_4000 ^ KEY)) begin n_err++; $display("[TB] FAIL rdw_id: got v=%b pc=%h instr=%h, required v=1 pc=00004000 instr=%h", id_valid, id_pc, id_instr, 32'h0000_4000 ^ KEY); end
      end
    end
  endtask

  task automatic test_redirect_same_cycle(input logic [31:0] tgt);
    logic [31:0] al;
    al = {tgt[31:2], 2'b00};
    do_reset(1);
    next_cycle();
    redirect = 1'b1;
    redirect_pc = tgt;
    next_cycle();
    redirect = 1'b0;
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rds_drop: got id_valid=%b, required 0", id_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== al) begin n_err++; $display("[TB] FAIL rds_req: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, al); end
    repeat (2) next_cycle();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== al || id_pc_plus4 !== al + 32'd4) begin n_err++; $display("[TB] FAIL rds_id: got v=%b pc=%h plus4=%h, required v=1 pc=%h plus4=%h", id_valid, id_pc, id_pc_plus4, al, al + 32'd4); end
  endtask

  task automatic test_wrap();
    test_redirect_same_cycle(32'hFFFF_FFFC);
    n_cmp++; if (id_pc_plus4 !== 32'h0) begin n_err++; $display("[TB] FAIL wrap_plus4: got %h, required 00000000", id_pc_plus4); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("[TB] FAIL wrap_addr: got req=%b addr=%h, required req=1 addr=00000000", imem_req, imem_addr); end
    repeat (2) next_cycle();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin n_err++; $display("[TB] FAIL wrap_next: got v=%b pc=%h plus4=%h, required v=1 pc=0 plus4=4", id_valid, id_pc, id_pc_plus4); end
  endtask

  task automatic test_reset_midway();
    do_reset(1);
    repeat (2) next_cycle();
    stall = 1'b1;
    next_cycle();
    n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("[TB] FAIL mid_precond: got id_valid=%b, required 1", id_valid); end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0) begin n_err++; $display("[TB] FAIL mid_async: got v=%b pc=%h instr=%h, required all 0", id_valid, id_pc, id_instr); end
    next_cycle();
    rstn = 1'b1;
    stall = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_err++; $display("[TB] FAIL mid_restart: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, RESET_PC); end
    repeat (2) next_cycle();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== RESET_PC) begin n_err++; $display("[TB] FAIL mid_first: got v=%b pc=%h, required v=1 pc=%h", id_valid, id_pc, RESET_PC); end
  endtask

  task automatic test_random();
    do_reset(1);
    mem_rand = 1'b1;
    consumed = 0;
    for (int i = 0; i < 2000; i++) begin
      next_cycle();
      stall = ($urandom % 3 == 0);
      redirect = ($urandom % 30 == 0);
      redirect_pc = $urandom;
    end
    next_cycle();
    stall = 1'b0;
    redirect = 1'b0;
    mem_rand = 1'b0;
    n_cmp++; if (consumed < 100) begin n_err++; $display("[TB] FAIL random_progress: got %0d consumed, required at least 100", consumed); end
  endtask

  initial begin
    $display("[TB] fetch_stage bench start");
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_same_cycle($urandom);
    test_wrap();
    test_reset_midway();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS CPU: holds the PC, issues one word request at a time to instruction memory, and presents each fetched instruction with its PC to decode. Decode is where the 5-bit and 16-bit immediate extenders sit. Branch and jump targets come back on the redirect port; they are computed downstream from the sign-extended 16-bit immediate or the jump field. Includes a one-entry skid buffer so that a decode stall never drops a returning memory word.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset (bits [1:0] must be 0)
- clk  input  1  system clock; all state updates on its rising edge
- rstn  input  1  asynchronous, active-low reset
- imem_req  output  1  one-cycle request pulse; memory always accepts it
- imem_addr  output  32  word address of the request; valid when imem_req=1
- imem_rdata  input  32  returned instruction word
- imem_valid  input  1  response strobe; arrives ≥1 cycle after imem_req; at most one request outstanding
- stall  input  1  decode cannot accept a new instruction this cycle
- redirect  input  1  branch or jump taken; flush the pipeline and refetch
- redirect_pc  input  32  new fetch address; bits [1:0] are forced to 0
- id_valid  output  1  id_instr, id_pc and id_pc_plus4 hold a live instruction
- id_instr  output  32  fetched instruction
- id_pc  output  32  address of id_instr
- id_pc_plus4  output  32  id_pc + 4, modulo 2^32

## Operation
- Registers:
  - pc: next fetch address
  - req_pc: address of the outstanding request
  - state
  - kill: discard the pending response
  - skid_valid, skid_instr, skid_pc
  - id output register
- States:
  - S_REQ: imem_req=1, imem_addr=pc; req_pc←pc; pc←pc+4; go to S_WAIT.
  - S_WAIT: wait for imem_valid. On imem_valid:
    - if kill=1: drop the word, clear kill, go to S_REQ.
    - else if the id slot is free (!id_valid || !stall): load the id register, go to S_REQ.
    - else: load the skid buffer, go to S_SKID.
  - S_SKID: no requests. When !stall, move the skid buffer into the id register, clear skid_valid, go to S_REQ.
- Id register: when the slot is free and nothing new is loaded, id_valid←0. id_valid is held unchanged while stall=1.
- Redirect has priority over everything else in the same cycle:
  - pc←{redirect_pc[31:2],2'b00}; id_valid←0; skid_valid←0.
  - In S_REQ: the request still issues. Set kill←1 and go to S_WAIT; pc takes the redirect value, not pc+4.
  - In S_WAIT without imem_valid: kill←1; stay in S_WAIT.
  - In S_WAIT with imem_valid: drop the word; go to S_REQ.
  - In S_SKID: go to S_REQ.
- Arithmetic: all PC adds are 32-bit unsigned and wrap, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- imem_valid is ignored outside S_WAIT.

## Timing
- Reset (asynchronous, rstn=0):
  - state=S_REQ, pc=RESET_PC, req_pc=0, kill=0, skid_valid=0.
  - id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0.
  - imem_req is combinational from state, so it reads 1 immediately after rstn rises.
- Latency with a 1-cycle memory:
  - Request in cycle N, imem_valid in N+1, id_valid=1 from N+2.
  - Peak throughput is one instruction per 2 cycles.
- Redirect in cycle N: id_valid=0 in N+1. The first request to the new PC goes out in N+1 (from S_SKID or S_WAIT-with-valid), or one cycle after the killed response returns.
- Reset mid-request: the outstanding request is forgotten. The memory is reset by the same rstn and must not deliver stale responses.

## Structure
- Shared package mips_pkg:
  - fetch_state_t: S_REQ, S_WAIT, S_SKID, 2-bit encoding
  - RESET_PC_DEFAULT
  - WORD_BYTES = 4
- Sub-module if_id_reg: id output register plus skid buffer, with load/hold/flush controls. The FSM and PC logic stay in fetch_stage.

## Test plan
- Reset, then 1-cycle memory returning addr^32'hA5A5_A5A5 with no stall → id_pc sequence 0x3000, 0x3004, 0x3008, each with id_valid high from cycle 2, one new instruction every 2 cycles.
- Hold stall=1 for 5 cycles while a response returns → skid captures it, no new imem_req during S_SKID; after release, ids arrive in order 0x3000, 0x3004 with none lost or duplicated.
- Redirect to 0x4001 during S_WAIT, memory latency 3 → old response discarded (id_valid stays 0), next imem_addr=0x4000, id_pc=0x4000.
- Redirect in the same cycle as imem_valid → word dropped; next cycle imem_req=1 with imem_addr=redirect target.
- Redirect to 0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000; id_pc_plus4 for the first is 0x0000_0000.
- Assert rstn=0 while in S_WAIT with id_valid=1 → id_valid=0 immediately; after release, imem_addr=RESET_PC.
